// File: rtl/elixirchip_es1_spu_logic_pkg.sv
// elixirchip_es1_spu_logic_pkg: shared op codes and bitwise function for SPU logic ops
package elixirchip_es1_spu_logic_pkg;
  localparam int MAX_BITS = 64;
  typedef logic [MAX_BITS-1:0] word_t;
  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_ANDN  = 3'd6,
    OP_PASS0 = 3'd7
  } op_t;
  function automatic word_t logic_apply(op_t op, word_t a, word_t b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      OP_XNOR: return ~(a ^ b);
      OP_ANDN: return a & ~b;
      default: return a;
    endcase
  endfunction
endpackage

// File: rtl/elixirchip_es1_spu_delay.sv
// elixirchip_es1_spu_delay: cke-qualified delay line of any packed type; depth 0 is a wire
module elixirchip_es1_spu_delay #(
  parameter int  LATENCY     = 1,
  parameter type t           = logic,
  parameter t    RESET_VALUE = t'(0)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cke,
  input  t     s,
  output t     m
);
  if (LATENCY == 0) begin : g_wire
    assign m = s;
  end else begin : g_pipe
    t pipe [LATENCY];
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int i = 0; i < LATENCY; i++) pipe[i] <= RESET_VALUE;
      end else if (cke) begin
        pipe[0] <= s;
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign m = pipe[LATENCY-1];
  end
endmodule

// File: rtl/elixirchip_es1_spu_op_logic.sv
// elixirchip_es1_spu_op_logic: multi-lane selectable bitwise operator with accumulate,
// clear and an aligned valid pipe.
module elixirchip_es1_spu_op_logic
  import elixirchip_es1_spu_logic_pkg::*;
#(
  parameter int    LATENCY          = 1,
  parameter int    DATA_BITS        = 8,
  parameter int    NUM_CH           = 2,
  parameter type   data_t           = logic [DATA_BITS-1:0],
  parameter data_t CLEAR_DATA       = '1,
  parameter bit    IMMEDIATE_DATA1  = 1'b0,
  parameter data_t IMMEDIATE_VALUE1 = '0,
  parameter string DEVICE           = "RTL",
  parameter string SIMULATION       = "false",
  parameter string DEBUG            = "false"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cke,
  input  logic [2:0]              s_op,
  input  logic                    s_acc,
  input  data_t [NUM_CH-1:0]      s_data0,
  input  data_t [NUM_CH-1:0]      s_data1,
  input  logic                    s_clear,
  input  logic                    s_valid,
  output data_t [NUM_CH-1:0]      m_data,
  output logic                    m_valid
);
  typedef data_t [NUM_CH-1:0] vec_t;
  vec_t st1;
  logic valid_q;
  // vendor/debug knobs exist only for interface compatibility with sibling ops
  if (DEVICE == "" && SIMULATION == "" && DEBUG == "") begin : g_knobs
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    data_t q;
    data_t op1;
    assign op1 = s_acc ? q : IMMEDIATE_DATA1 ? IMMEDIATE_VALUE1 : s_data1[i];
    always_ff @(posedge clk) begin
      if (!reset_n) q <= CLEAR_DATA;
      else if (cke) q <= s_clear ? CLEAR_DATA
                       : s_valid ? data_t'(logic_apply(op_t'(s_op), word_t'(s_data0[i]), word_t'(op1)))
                       : q;
    end
    assign st1[i] = q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) valid_q <= 1'b0;
    else if (cke) valid_q <= s_valid;
  end
  elixirchip_es1_spu_delay #(
    .LATENCY(LATENCY - 1), .t(vec_t), .RESET_VALUE(vec_t'({NUM_CH{CLEAR_DATA}}))
  ) u_data (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s(st1), .m(m_data)
  );
  elixirchip_es1_spu_delay #(
    .LATENCY(LATENCY - 1), .t(logic), .RESET_VALUE(1'b0)
  ) u_valid (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s(valid_q), .m(m_valid)
  );
endmodule

// File: tb/tb_elixirchip_es1_spu_op_logic.sv
// tb_elixirchip_es1_spu_op_logic: scoreboard bench for the SPU logic operator,
// one register-file DUT and one immediate-operand DUT driven in parallel.
module tb_elixirchip_es1_spu_op_logic;
  localparam int L = 2;
  typedef logic [7:0] d_t;
  typedef struct packed {logic v; d_t [1:0] d; d_t [1:0] di;} ent_t;
  logic clk = 0, reset_n = 1, cke = 1, s_acc = 0, s_clear = 0, s_valid = 0;
  logic [2:0] s_op = 0;
  d_t [1:0] s_data0 = '0, s_data1 = '0, m_data, im_data;
  logic m_valid, im_valid;
  d_t [1:0] st1, st1i;
  ent_t cur, pipe[$], sb[$], e;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  elixirchip_es1_spu_op_logic #(
    .LATENCY(L), .DATA_BITS(8), .NUM_CH(2), .CLEAR_DATA(8'hFF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_op(s_op), .s_acc(s_acc),
    .s_data0(s_data0), .s_data1(s_data1), .s_clear(s_clear), .s_valid(s_valid),
    .m_data(m_data), .m_valid(m_valid)
  );
  elixirchip_es1_spu_op_logic #(
    .LATENCY(L), .DATA_BITS(8), .NUM_CH(2), .CLEAR_DATA(8'hFF),
    .IMMEDIATE_DATA1(1'b1), .IMMEDIATE_VALUE1(8'h5A)
  ) dut_imm (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_op(s_op), .s_acc(s_acc),
    .s_data0(s_data0), .s_data1(s_data1), .s_clear(s_clear), .s_valid(s_valid),
    .m_data(im_data), .m_valid(im_valid)
  );
  function automatic d_t ref_op(logic [2:0] op, d_t a, d_t b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a;
    endcase
  endfunction
  function automatic logic rnd_cke();
    return $urandom_range(9) != 0;
  endfunction
  // drives one edge, advances the reference pipeline and queues the output expected after it
  task automatic drive(input logic rn, input logic ck, input logic [2:0] op, input logic acc,
                       input logic clr, input logic vld, input d_t [1:0] a, input d_t [1:0] b);
    d_t [1:0] n, ni;
    @(negedge clk);
    reset_n = rn; cke = ck; s_op = op; s_acc = acc; s_clear = clr; s_valid = vld;
    s_data0 = a; s_data1 = b;
    @(posedge clk);
    if (!rn) begin
      st1 = {2{8'hFF}};
      st1i = {2{8'hFF}};
      cur = '{v: 1'b0, d: {2{8'hFF}}, di: {2{8'hFF}}};
      pipe.delete();
      for (int k = 0; k < L - 1; k++) pipe.push_back(cur);
    end else if (ck) begin
      for (int i = 0; i < 2; i++) begin
        n[i]  = clr ? 8'hFF : vld ? ref_op(op, a[i], acc ? st1[i] : b[i]) : st1[i];
        ni[i] = clr ? 8'hFF : vld ? ref_op(op, a[i], acc ? st1i[i] : 8'h5A) : st1i[i];
      end
      st1 = n;
      st1i = ni;
      pipe.push_back('{v: vld, d: n, di: ni});
      cur = pipe.pop_front();
    end
    sb.push_back(cur);
    #1;
  endtask
  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      drive(c >= 3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
      e = sb.pop_front(); total++;
      if (m_data !== e.d || m_valid !== e.v || im_data !== e.di || im_valid !== e.v)
        begin bad++; $display("FAIL reset_sb: got %h/%b %h want %h/%b %h", m_data, m_valid, im_data, e.d, e.v, e.di); end
      total++;
      if (m_data !== 16'hFFFF || m_valid !== 1'b0)
        begin bad++; $display("FAIL reset_val: got %h/%b want ffff/0", m_data, m_valid); end
    end
  endtask
  task automatic test_function();
    d_t exp0 [8] = '{8'h03, 8'h3F, 8'h3C, 8'hFC, 8'hC0, 8'hC3, 8'h0C, 8'h0F};
    d_t vals [3];
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 1'b1, 3'(k), 1'b0, 1'b0, k < 8, {8'h00, 8'h0F}, {8'hFF, 8'h33});
      e = sb.pop_front(); total++;
      if (m_data !== e.d || m_valid !== e.v || im_data !== e.di || im_valid !== e.v)
        begin bad++; $display("FAIL func_sb op%0d: got %h/%b %h want %h/%b %h", k, m_data, m_valid, im_data, e.d, e.v, e.di); end
      if (k > 0) begin
        total++;
        if (m_data[0] !== exp0[k-1] || m_valid !== 1'b1)
          begin bad++; $display("FAIL func_lane0 op%0d: got %h/%b want %h/1", k - 1, m_data[0], m_valid, exp0[k-1]); end
      end
    end
    for (int a = 0; a < 3; a++) for (int b = 0; b < 3; b++) for (int op = 0; op < 8; op++)
      for (int m = 0; m < 2; m++) begin
        vals = '{8'h00, 8'hFF, d_t'($urandom)};
        drive(1'b1, rnd_cke(), 3'(op), 1'($urandom_range(1)), m == 0, m == 1,
              {d_t'($urandom), vals[a]}, {d_t'($urandom), vals[b]});
        e = sb.pop_front(); total++;
        if (m_data !== e.d || m_valid !== e.v || im_data !== e.di || im_valid !== e.v)
          begin bad++; $display("FAIL sweep op%0d: got %h/%b %h want %h/%b %h", op, m_data, m_valid, im_data, e.d, e.v, e.di); end
      end
  endtask
  task automatic test_hold();
    drive(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, {2{8'h0F}}, {2{8'hF0}});
    void'(sb.pop_front());
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b1, 3'($urandom), 1'b0, 1'b0, 1'b0, $urandom, $urandom);
      e = sb.pop_front(); total++;
      if (m_data !== e.d || m_valid !== e.v)
        begin bad++; $display("FAIL hold_sb: got %h/%b want %h/%b", m_data, m_valid, e.d, e.v); end
      total++;
      if (m_data !== 16'hFFFF || m_valid !== (c == 0))
        begin bad++; $display("FAIL hold_val: got %h/%b want ffff/%b", m_data, m_valid, c == 0); end
    end
  endtask
  task automatic test_clear();
    drive(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    drive(1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h5678);
    drive(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    void'(sb.pop_front()); void'(sb.pop_front());
    e = sb.pop_front(); total++;
    if (m_data !== e.d || m_valid !== e.v || m_data !== 16'hFFFF || m_valid !== 1'b1)
      begin bad++; $display("FAIL clear_prio: got %h/%b want ffff/1 (model %h/%b)", m_data, m_valid, e.d, e.v); end
  endtask
  task automatic test_acc(input bit stall);
    d_t seq [3] = '{8'hF7, 8'h7F, 8'h3C};
    drive(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    void'(sb.pop_front());
    for (int k = 0; k < 3; k++) begin
      if (stall && k == 2)
        for (int c = 0; c < 3; c++) begin
          drive(1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, $urandom, $urandom);
          void'(sb.pop_front());
        end
      drive(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, {2{seq[k]}}, $urandom);
      e = sb.pop_front(); total++;
      if (m_data !== e.d || m_valid !== e.v || im_data !== e.di)
        begin bad++; $display("FAIL acc_sb stall=%0d step%0d: got %h/%b want %h/%b", stall, k, m_data, m_valid, e.d, e.v); end
    end
    drive(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    void'(sb.pop_front());
    total++;
    if (m_data !== 16'h3434 || m_valid !== 1'b1 || im_data !== 16'h3434)
      begin bad++; $display("FAIL acc_chain stall=%0d: got %h/%b %h want 3434/1 3434", stall, m_data, m_valid, im_data); end
  endtask
  task automatic test_immediate();
    drive(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 16'hFFFF, $urandom);
    drive(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 16'h0000, $urandom);
    void'(sb.pop_front());
    e = sb.pop_front(); total++;
    if (im_data !== e.di || im_data !== 16'hA5A5 || im_valid !== 1'b1)
      begin bad++; $display("FAIL immediate: got %h/%b want a5a5/1 (model %h)", im_data, im_valid, e.di); end
  endtask
  task automatic test_mid_reset();
    drive(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0F0F);
    void'(sb.pop_front());
    drive(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 16'h5555, 16'h0F0F);
    void'(sb.pop_front());
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
      e = sb.pop_front(); total++;
      if (m_data !== e.d || m_valid !== e.v || m_data !== 16'hFFFF || m_valid !== 1'b0)
        begin bad++; $display("FAIL mid_reset: got %h/%b want ffff/0 (model %h/%b)", m_data, m_valid, e.d, e.v); end
    end
  endtask
  initial begin
    test_reset();
    test_function();
    test_hold();
    test_clear();
    test_acc(1'b0);
    test_acc(1'b1);
    test_immediate();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
